// File: rtl/hex_display_sched.sv
// hex_display_sched: two-requester scheduler for a six-digit hex display.
// A granted source stays on the display for at least HOLD_CYCLES unfrozen cycles.
// At the end of that time the other requester wins a tie, and re-granting the
// same source refreshes its data. Leading-zero blanking is computed from the
// captured value on the same edge that captures it.
module hex_display_sched #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter bit          LZ_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  req_valid,
  input  logic [23:0] req_data0,
  input  logic [23:0] req_data1,
  input  logic        freeze,
  output logic [1:0]  req_ack,
  output logic [23:0] digits,
  output logic [5:0]  blank,
  output logic        src_sel,
  output logic        disp_valid
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          last_src_reg, last_src_next;

  logic          at_term;
  logic          grant;
  logic          grant_src;

  logic [1:0]    ack_next;
  logic [23:0]   digits_next;
  logic [5:0]    blank_next;
  logic          src_sel_next;
  logic          disp_valid_next;
  logic [5:1]    upper_zero;

  assign at_term = (count_reg == TERM);

  // State, hold counter, arbitration history and all visible outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      last_src_reg <= 1'b1;  // requester 0 wins the first tie
      req_ack      <= 2'b00;
      digits       <= 24'h0;
      blank        <= 6'h3F;
      src_sel      <= 1'b0;
      disp_valid   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      last_src_reg <= last_src_next;
      req_ack      <= ack_next;
      digits       <= digits_next;
      blank        <= blank_next;
      src_sel      <= src_sel_next;
      disp_valid   <= disp_valid_next;
    end
  end

  // Grant decision, next state and hold-counter update
  always_comb begin
    grant      = 1'b0;
    grant_src  = 1'b0;
    state_next = state_reg;
    count_next = count_reg;
    if (!freeze && (state_reg == IDLE || at_term) && (|req_valid)) begin
      grant     = 1'b1;
      // On a tie, alternate away from the last source; otherwise take the one asking
      grant_src = (&req_valid) ? ~last_src_reg : req_valid[1];
    end
    if (grant) begin
      state_next = HOLD;
      count_next = '0;
    end else if (state_reg == HOLD && !freeze && !at_term) begin
      count_next = count_reg + 1'b1;  // saturates at the terminal count
    end
  end

  // Next values of the registered outputs
  always_comb begin
    ack_next        = 2'b00;
    digits_next     = digits;
    src_sel_next    = src_sel;
    last_src_next   = last_src_reg;
    disp_valid_next = disp_valid | grant;
    if (grant) begin
      digits_next   = grant_src ? req_data1 : req_data0;
      src_sel_next  = grant_src;
      last_src_next = grant_src;
      ack_next      = grant_src ? 2'b10 : 2'b01;
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero
  generate
    for (genvar gi = 1; gi < 6; gi++) begin : g_lz
      assign upper_zero[gi] = (digits_next[23:4*gi] == '0);
    end
  endgenerate

  // Blanking mask for the value about to be displayed; the rightmost digit always shows
  always_comb begin
    blank_next = 6'h3F;
    if (disp_valid_next) begin
      blank_next = {upper_zero & {5{LZ_SUPPRESS}}, 1'b0};
    end
  end

endmodule

// File: tb/tb_hex_display_sched.sv
// tb_hex_display_sched: directed scenarios plus randomized traffic, checked
// against a behavioural model of the scheduler (HOLD_CYCLES=4, LZ_SUPPRESS=1).
module tb_hex_display_sched;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [23:0] req_data0 = 24'h0;
  logic [23:0] req_data1 = 24'h0;
  logic        freeze = 1'b0;
  logic [1:0]  req_ack;
  logic [23:0] digits;
  logic [5:0]  blank;
  logic        src_sel;
  logic        disp_valid;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_shown;
  logic [23:0] m_digits;
  int          m_src;
  int          m_last;
  int          m_age;     // unfrozen cycles since the last grant
  logic [1:0]  m_ack;

  hex_display_sched #(.HOLD_CYCLES(HOLD), .LZ_SUPPRESS(1'b1)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .freeze(freeze),
    .req_ack(req_ack), .digits(digits), .blank(blank),
    .src_sel(src_sel), .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance the model by one edge using the current inputs, then the clock
  task automatic tick();
    int g;
    if (!resetn) begin
      m_shown = 0; m_digits = 24'h0; m_src = 0; m_last = 1; m_age = 0; m_ack = 2'b00;
    end else begin
      m_ack = 2'b00;
      if (!freeze && (!m_shown || m_age >= HOLD - 1) && req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? (1 - m_last) : (req_valid[1] ? 1 : 0);
        m_digits = g ? req_data1 : req_data0;
        m_src = g; m_last = g; m_shown = 1; m_age = 0;
        m_ack = (g == 1) ? 2'b10 : 2'b01;
      end else if (m_shown && !freeze) begin
        m_age++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] exp_blank();
    logic [5:0] b;
    if (!m_shown) return 6'h3F;
    b = 6'h00;
    for (int i = 5; i >= 1; i--) begin
      if (m_digits[4*i +: 4] != 4'h0) break;
      b[i] = 1'b1;
    end
    return b;
  endfunction

  // Packed expectation: {ack, src_sel, disp_valid, blank, digits}
  function automatic logic [33:0] exp_vec();
    return {m_ack, (m_src == 1), m_shown, exp_blank(), m_digits};
  endfunction

  function automatic logic [23:0] rand_data();
    logic [23:0] mask;
    mask = 24'hFFFFFF >> (4 * $urandom_range(0, 6));
    return 24'($urandom) & mask;
  endfunction

  task automatic do_reset();
    resetn = 1'b0; req_valid = 2'b00; freeze = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 2'b11;
    req_data0 = 24'h123456; req_data1 = 24'h654321;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({req_ack, src_sel, disp_valid, blank, digits} !== {2'b00, 1'b0, 1'b0, 6'h3F, 24'h0}) begin
        errors++;
        $display("FAIL reset[%0d]: got ack=%b src=%b dv=%b blank=%h digits=%h, want ack=00 src=0 dv=0 blank=3f digits=000000",
                 i, req_ack, src_sel, disp_valid, blank, digits);
      end
    end
    resetn = 1'b1; req_valid = 2'b00;
    $display("test_reset done");
  endtask

  task automatic test_first_grant();
    do_reset();
    req_valid = 2'b01; req_data0 = 24'h00012A; req_data1 = rand_data();
    tick();
    checks++;
    if ({req_ack, src_sel, disp_valid, blank, digits} !== {2'b01, 1'b0, 1'b1, 6'b111000, 24'h00012A}) begin
      errors++;
      $display("FAIL first_grant: got ack=%b src=%b dv=%b blank=%b digits=%h, want ack=01 src=0 dv=1 blank=111000 digits=00012a",
               req_ack, src_sel, disp_valid, blank, digits);
    end
    req_valid = 2'b00;
    tick();
    checks++;
    if ({req_ack, src_sel, disp_valid, blank, digits} !== {2'b00, 1'b0, 1'b1, 6'b111000, 24'h00012A}) begin
      errors++;
      $display("FAIL first_grant_ack_width: got ack=%b digits=%h blank=%b, want ack=00 digits=00012a blank=111000",
               req_ack, digits, blank);
    end
    $display("test_first_grant done");
  endtask

  task automatic test_round_robin();
    int gcyc[$];
    int gsrc[$];
    int want_c[4] = '{0, 4, 8, 12};
    int want_s[4] = '{0, 1, 0, 1};
    do_reset();
    req_valid = 2'b11; req_data0 = rand_data(); req_data1 = rand_data();
    for (int c = 0; c < 16; c++) begin
      tick();
      checks++;
      if ({req_ack, src_sel, disp_valid, blank, digits} !== exp_vec()) begin
        errors++;
        $display("FAIL round_robin cyc %0d: got %h, model %h", c, {req_ack, src_sel, disp_valid, blank, digits}, exp_vec());
      end
      if (req_ack != 2'b00) begin
        gcyc.push_back(c);
        gsrc.push_back(req_ack[1] ? 1 : 0);
        if (req_ack[0]) req_data0 = rand_data();
        if (req_ack[1]) req_data1 = rand_data();
      end
    end
    checks++;
    if (gcyc.size() != 4) begin
      errors++;
      $display("FAIL round_robin_count: got %0d grants, want 4", gcyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gcyc[i] != want_c[i] || gsrc[i] != want_s[i]) begin
          errors++;
          $display("FAIL round_robin_grant %0d: got cyc %0d src %0d, want cyc %0d src %0d",
                   i, gcyc[i], gsrc[i], want_c[i], want_s[i]);
        end
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_freeze();
    int second = -1;
    int second_src = -1;
    do_reset();
    req_valid = 2'b11; req_data0 = rand_data(); req_data1 = rand_data();
    for (int t = 0; t < 20 && second < 0; t++) begin
      freeze = (t >= 2 && t <= 4);
      tick();
      checks++;
      if ({req_ack, src_sel, disp_valid, blank, digits} !== exp_vec()) begin
        errors++;
        $display("FAIL freeze cyc %0d: got %h, model %h", t, {req_ack, src_sel, disp_valid, blank, digits}, exp_vec());
      end
      if (t > 0 && req_ack != 2'b00) begin
        second = t;
        second_src = req_ack[1] ? 1 : 0;
      end
    end
    freeze = 1'b0;
    checks++;
    if (second != 7 || second_src != 1) begin
      errors++;
      $display("FAIL freeze_delay: got switch at cyc %0d src %0d, want cyc 7 src 1", second, second_src);
    end
    $display("test_freeze done");
  endtask

  task automatic test_refresh();
    do_reset();
    req_valid = 2'b01; req_data0 = 24'h000F00; req_data1 = rand_data();
    for (int t = 0; t <= 4; t++) begin
      if (t == 2) req_data0 = 24'hABCDEF;
      tick();
      checks++;
      if ({req_ack, src_sel, disp_valid, blank, digits} !== exp_vec()) begin
        errors++;
        $display("FAIL refresh cyc %0d: got %h, model %h", t, {req_ack, src_sel, disp_valid, blank, digits}, exp_vec());
      end
    end
    checks++;
    if ({req_ack, src_sel, disp_valid, blank, digits} !== {2'b01, 1'b0, 1'b1, 6'h00, 24'hABCDEF}) begin
      errors++;
      $display("FAIL refresh_abcdef: got ack=%b blank=%b digits=%h, want ack=01 blank=000000 digits=abcdef",
               req_ack, blank, digits);
    end
    req_data0 = 24'h0;
    for (int t = 5; t <= 8; t++) tick();
    checks++;
    if ({req_ack, src_sel, disp_valid, blank, digits} !== {2'b01, 1'b0, 1'b1, 6'b111110, 24'h0}) begin
      errors++;
      $display("FAIL refresh_zero: got ack=%b blank=%b digits=%h, want ack=01 blank=111110 digits=000000",
               req_ack, blank, digits);
    end
    $display("test_refresh done");
  endtask

  task automatic test_idle_terminal();
    logic [23:0] shown;
    logic [23:0] d1;
    do_reset();
    shown = rand_data();
    req_valid = 2'b01; req_data0 = shown;
    tick();
    req_valid = 2'b00;
    for (int t = 1; t <= 13; t++) begin
      tick();
      checks++;
      if (req_ack !== 2'b00 || digits !== shown || disp_valid !== 1'b1 || src_sel !== 1'b0) begin
        errors++;
        $display("FAIL idle_terminal cyc %0d: got ack=%b digits=%h dv=%b src=%b, want ack=00 digits=%h dv=1 src=0",
                 t, req_ack, digits, disp_valid, src_sel, shown);
      end
    end
    d1 = rand_data();
    req_valid = 2'b10; req_data1 = d1;
    tick();
    checks++;
    if (req_ack !== 2'b10 || digits !== d1 || src_sel !== 1'b1 || blank !== exp_blank()) begin
      errors++;
      $display("FAIL idle_terminal_grant: got ack=%b digits=%h src=%b blank=%b, want ack=10 digits=%h src=1 blank=%b",
               req_ack, digits, src_sel, blank, d1, exp_blank());
    end
    req_valid = 2'b00;
    $display("test_idle_terminal done");
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req_valid = 2'b11; req_data0 = rand_data(); req_data1 = rand_data();
    tick(); tick(); tick();
    resetn = 1'b0;
    tick();
    checks++;
    if ({req_ack, src_sel, disp_valid, blank, digits} !== {2'b00, 1'b0, 1'b0, 6'h3F, 24'h0}) begin
      errors++;
      $display("FAIL reset_mid_hold: got ack=%b src=%b dv=%b blank=%h digits=%h, want 00 0 0 3f 000000",
               req_ack, src_sel, disp_valid, blank, digits);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (req_ack !== 2'b01 || src_sel !== 1'b0 || digits !== req_data0) begin
      errors++;
      $display("FAIL reset_first_tie: got ack=%b src=%b digits=%h, want ack=01 src=0 digits=%h",
               req_ack, src_sel, digits, req_data0);
    end
    req_valid = 2'b00;
    $display("test_reset_mid_hold done");
  endtask

  task automatic test_random();
    logic [1:0] last_ack = 2'b00;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      resetn = ($urandom_range(0, 49) != 0);
      freeze = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 2; i++) begin
        if (last_ack[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          if (i == 0) req_data0 = rand_data(); else req_data1 = rand_data();
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      tick();
      last_ack = req_ack;
      checks++;
      if ({req_ack, src_sel, disp_valid, blank, digits} !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h, model %h", c, {req_ack, src_sel, disp_valid, blank, digits}, exp_vec());
      end
    end
    resetn = 1'b1; freeze = 1'b0; req_valid = 2'b00;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_freeze();
    test_refresh();
    test_idle_terminal();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
